// File: rtl/tx_serial_cfg_pkg.sv
// Shared definitions for the configurable serial transmitter (and its matching receiver).
// Contents:
//   tx_state_t      FSM state codes; the raw code is exported on db_estado
//   PAR_*           run-time parity mode codes carried on the paridade input
//   parity_enabled  true when a mode inserts a parity bit into the frame
package tx_serial_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Code 2'b11 is reserved and behaves like PAR_NONE.
   function automatic logic parity_enabled(input logic [1:0] mode);
      case (mode)
         PAR_NONE:          return 1'b0;
         PAR_EVEN, PAR_ODD: return 1'b1;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/tx_serial_fifo.sv
// Synchronous FIFO feeding the serial transmitter.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high flush
//   push   in   write din (ignored when full)
//   pop    in   advance read pointer (ignored when empty)
//   din    in   WIDTH-bit write data
//   dout   out  WIDTH-bit head of queue (combinational read)
//   full   out  DEPTH words stored
//   empty  out  no words stored
// There is no push-to-pop bypass: a word written on an edge is visible at dout only after it.
module tx_serial_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tx_serial_cfg.sv
// Configurable asynchronous serial transmitter with input FIFO.
// Words are serialised LSB first as: start(0), DATA_BITS data, optional parity, 1 or 2 stop(1).
// Parity mode and stop count are captured per frame when the word leaves the FIFO.
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset; abandons any frame and flushes the FIFO
//   dados         in   word to transmit
//   escreve       in   host valid; word is taken when escreve && aceita
//   aceita        out  FIFO not full
//   paridade      in   00 none, 01 even, 10 odd, 11 none
//   dois_stop     in   0: one stop bit, 1: two stop bits
//   saida_serial  out  registered TX line, idle high
//   ocupado       out  frame in progress
//   pronto        out  one-cycle pulse on the last cycle of each frame
//   db_estado     out  raw FSM state code
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for a queued word
// ST_START  | start bit (line low)
// ST_DATA   | data bits, LSB first; bit_cnt counts bits sent
// ST_PARITY | parity bit computed when the word was popped
// ST_STOP   | stop bit(s); bit_cnt counts stop bits; may chain straight into ST_START
module tx_serial_cfg
   import tx_serial_cfg_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] dados,
   input  logic                 escreve,
   output logic                 aceita,
   input  logic [1:0]           paridade,
   input  logic                 dois_stop,
   output logic                 saida_serial,
   output logic                 ocupado,
   output logic                 pronto,
   output logic [3:0]           db_estado
);

   localparam int                BAUD_W    = $clog2(CLK_DIV);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);

   tx_state_t            state;
   tx_state_t            state_next;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 avail_q;
   logic                 frame_avail;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic [BAUD_W-1:0]    baud_cnt;
   logic                 baud_tick;
   logic [1:0]           par_mode;
   logic                 two_stop;
   logic                 par_bit;
   logic                 line_q;
   logic                 line_next;
   logic                 shift_en;
   logic                 bit_clr;
   logic                 bit_inc;
   logic [3:0]           stop_last;

   assign push = escreve && !fifo_full;

   tx_serial_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (dados),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The FSM looks at a one-cycle-old view of the FIFO level, which keeps the pop decision
   // off the count path and gives the two-edge push-to-start latency. Qualifying it with the
   // live empty flag guarantees a pop never hits an empty FIFO.
   assign frame_avail = avail_q && !fifo_empty;

   assign baud_tick = (baud_cnt == BAUD_LAST);
   assign stop_last = two_stop ? 4'd1 : 4'd0;

   assign aceita       = !fifo_full;
   assign saida_serial = line_q;
   assign ocupado      = (state != ST_IDLE);
   assign db_estado    = {1'b0, state};

   always_comb begin
      state_next = state;
      line_next  = line_q;
      pop        = 1'b0;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      bit_inc    = 1'b0;
      pronto     = 1'b0;
      case (state)
         ST_IDLE: begin
            line_next = 1'b1;
            if (frame_avail) begin
               pop        = 1'b1;
               state_next = ST_START;
               line_next  = 1'b0;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               state_next = ST_DATA;
               line_next  = shreg[0];
               shift_en   = 1'b1;
               bit_clr    = 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt == BIT_LAST) begin
                  bit_clr = 1'b1;
                  if (parity_enabled(par_mode)) begin
                     state_next = ST_PARITY;
                     line_next  = par_bit;
                  end else begin
                     state_next = ST_STOP;
                     line_next  = 1'b1;
                  end
               end else begin
                  line_next = shreg[0];
                  shift_en  = 1'b1;
                  bit_inc   = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) begin
               state_next = ST_STOP;
               line_next  = 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               if (bit_cnt == stop_last) begin
                  pronto = 1'b1;
                  if (frame_avail) begin
                     pop        = 1'b1;
                     state_next = ST_START;
                     line_next  = 1'b0;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            line_next  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         line_q   <= 1'b1;
         avail_q  <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         par_mode <= PAR_NONE;
         two_stop <= 1'b0;
         par_bit  <= 1'b0;
      end else begin
         state   <= state_next;
         line_q  <= line_next;
         avail_q <= !fifo_empty;

         if (pop) begin
            shreg    <= fifo_dout;
            par_mode <= paridade;
            two_stop <= dois_stop;
            par_bit  <= (paridade == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            bit_cnt  <= '0;
         end else begin
            if (shift_en) begin
               shreg <= shreg >> 1;
            end
            if (bit_clr) begin
               bit_cnt <= '0;
            end else if (bit_inc) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end

         // Baud counter only runs inside a frame and restarts on every frame start.
         if (pop || state == ST_IDLE || baud_tick) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_serial_cfg.sv
module tb_tx_serial_cfg;

   localparam int DB = 8;
   localparam int CD = 4;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dados = '0;
   logic       escreve = 1'b0;
   logic       aceita;
   logic [1:0] paridade = 2'b00;
   logic       dois_stop = 1'b0;
   logic       saida_serial;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;

   logic [6:0] dados_b = '0;
   logic       escreve_b = 1'b0;
   logic       aceita_b;
   logic [1:0] paridade_b = 2'b00;
   logic       dois_stop_b = 1'b0;
   logic       saida_b;
   logic       ocupado_b;
   logic       pronto_b;
   logic [3:0] db_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tx_serial_cfg #(.DATA_BITS(DB), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
      .clock(clk), .reset(reset), .dados(dados), .escreve(escreve), .aceita(aceita),
      .paridade(paridade), .dois_stop(dois_stop), .saida_serial(saida_serial),
      .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
   );

   tx_serial_cfg #(.DATA_BITS(7), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut_b (
      .clock(clk), .reset(reset), .dados(dados_b), .escreve(escreve_b), .aceita(aceita_b),
      .paridade(paridade_b), .dois_stop(dois_stop_b), .saida_serial(saida_b),
      .ocupado(ocupado_b), .pronto(pronto_b), .db_estado(db_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (main instance) ----------------
   typedef struct {
      logic [7:0] d;
      int         avail;
   } item_t;

   item_t mq[$];
   logic  seg[$];
   int    edge_n = 0;
   bit    m_busy = 0;
   int    m_pos = 0;
   int    m_len = 0;
   bit    m_par = 0;
   bit    m_acc;
   item_t m_it;

   always @(posedge clk) begin
      edge_n++;
      if (reset) begin
         mq.delete();
         m_busy = 0;
      end else begin
         m_acc = escreve && (mq.size() < FD);
         if (m_busy) begin
            m_pos++;
            if (m_pos == m_len) m_busy = 0;
         end
         if (!m_busy && mq.size() > 0 && mq[0].avail <= edge_n) begin
            seg.delete();
            seg.push_back(1'b0);
            for (int i = 0; i < DB; i++) seg.push_back(mq[0].d[i]);
            m_par = (paridade == 2'b01) || (paridade == 2'b10);
            if (m_par) seg.push_back((paridade == 2'b01) ? ^mq[0].d : ~^mq[0].d);
            seg.push_back(1'b1);
            if (dois_stop) seg.push_back(1'b1);
            m_len  = seg.size() * CD;
            m_pos  = 0;
            m_busy = 1;
            void'(mq.pop_front());
         end
         if (m_acc) begin
            m_it.d     = dados;
            m_it.avail = edge_n + 2;
            mq.push_back(m_it);
         end
      end
   end

   function automatic int exp_state();
      int k;
      if (!m_busy) return 0;
      k = m_pos / CD;
      if (k == 0) return 1;
      if (k <= DB) return 2;
      if (m_par && k == DB + 1) return 3;
      return 4;
   endfunction

   always @(negedge clk) begin
      chk("m_line",   32'(saida_serial), 32'(m_busy ? seg[m_pos / CD] : 1'b1));
      chk("m_busy",   32'(ocupado),      32'(m_busy));
      chk("m_pronto", 32'(pronto),       32'(m_busy && (m_pos == m_len - 1)));
      chk("m_aceita", 32'(aceita),       32'(mq.size() < FD));
      chk("m_state",  32'(db_estado),    32'(exp_state()));
   end

   // ---------------- run / pulse monitor ----------------
   int run = 0;
   int last_run = 0;
   int pr_total = 0;

   always @(negedge clk) begin
      if (ocupado) run++;
      else begin
         if (run > 0) last_run = run;
         run = 0;
      end
      if (pronto) pr_total++;
   end

   // ---------------- helpers ----------------
   task automatic push_hold(input logic [7:0] d, output logic first_ready);
      int g = 0;
      dados = d;
      escreve = 1'b1;
      first_ready = aceita;
      while (!aceita && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (!aceita) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: aceita stayed 0, expected 1");
      end
      @(negedge clk);
      escreve = 1'b0;
   endtask

   task automatic measure(input bit sel, output int lat, output int busy, output int pr_at,
                          output int npr, output logic [15:0] mid);
      lat = 0; busy = 0; pr_at = 0; npr = 0; mid = '0;
      while (!(sel ? ocupado_b : ocupado) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      while ((sel ? ocupado_b : ocupado) && busy < 200) begin
         busy++;
         if (sel ? pronto_b : pronto) begin
            pr_at = busy;
            npr++;
         end
         if ((busy % CD) == 3 && (busy / CD) < 16) mid[4'(busy / CD)] = sel ? saida_b : saida_serial;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int maxc);
      int g = 0;
      while (ocupado && g < maxc) begin
         @(negedge clk);
         g++;
      end
      chk("idle_timeout", 32'(ocupado), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_busy();
      int g = 0;
      while (!ocupado && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("start_timeout", 32'(ocupado), 32'd1);
   endtask

   logic [7:0]  w3 [5] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
   logic        rdy;
   int          lat, busy, pr_at, npr, pr0;
   logic [15:0] mid;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_line",   32'(saida_serial), 32'd1);
      chk("rst_busy",   32'(ocupado),      32'd0);
      chk("rst_pronto", 32'(pronto),       32'd0);
      chk("rst_aceita", 32'(aceita),       32'd1);
      chk("rst_state",  32'(db_estado),    32'd0);

      // 1: 0x55, even parity, one stop
      paridade = 2'b01; dois_stop = 1'b0;
      push_hold(8'h55, rdy);
      measure(1'b0, lat, busy, pr_at, npr, mid);
      chk("t1_latency", 32'(lat),   32'd2);
      chk("t1_len",     32'(busy),  32'd44);
      chk("t1_pronto",  32'(pr_at), 32'd44);
      chk("t1_npronto", 32'(npr),   32'd1);
      chk("t1_bits",    32'(mid),   32'h04AA);

      // 2: 0x07, odd parity, two stops
      paridade = 2'b10; dois_stop = 1'b1;
      push_hold(8'h07, rdy);
      measure(1'b0, lat, busy, pr_at, npr, mid);
      chk("t2_latency", 32'(lat),   32'd2);
      chk("t2_len",     32'(busy),  32'd48);
      chk("t2_pronto",  32'(pr_at), 32'd48);
      chk("t2_bits",    32'(mid),   32'h0C0E);

      // 3: fill the FIFO while a frame is in flight
      paridade = 2'b01; dois_stop = 1'b0;
      push_hold(8'h11, rdy);
      repeat (4) @(negedge clk);
      pr0 = pr_total;
      for (int i = 0; i < 5; i++) begin
         push_hold(w3[i], rdy);
         chk($sformatf("t3_ready%0d", i), 32'(rdy), (i < 4) ? 32'd1 : 32'd0);
      end
      wait_idle(600);
      chk("t3_contig", 32'(last_run),        32'd264);
      chk("t3_frames", 32'(pr_total - pr0),  32'd6);

      // 4: reset during data bit 3
      paridade = 2'b01;
      push_hold(8'hA5, rdy);
      push_hold(8'h5A, rdy);
      wait_busy();
      repeat (17) @(negedge clk);
      chk("t4_in_data", 32'(db_estado), 32'd2);
      pr0 = pr_total;
      reset = 1'b1;
      @(negedge clk);
      chk("t4_line",   32'(saida_serial), 32'd1);
      chk("t4_busy",   32'(ocupado),      32'd0);
      chk("t4_aceita", 32'(aceita),       32'd1);
      chk("t4_state",  32'(db_estado),    32'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("t4_flushed", 32'(ocupado),        32'd0);
      chk("t4_nopulse", 32'(pr_total - pr0), 32'd0);

      // 5: parity switched off mid-frame
      paridade = 2'b01; dois_stop = 1'b0;
      push_hold(8'h33, rdy);
      push_hold(8'h0F, rdy);
      wait_busy();
      repeat (8) @(negedge clk);
      paridade = 2'b00;
      pr0 = pr_total;
      wait_idle(300);
      chk("t5_len",    32'(last_run),       32'd84);
      chk("t5_frames", 32'(pr_total - pr0), 32'd2);

      // 6: 7-bit instance, 0x41, no parity
      dados_b = 7'h41; escreve_b = 1'b1;
      @(negedge clk);
      escreve_b = 1'b0;
      measure(1'b1, lat, busy, pr_at, npr, mid);
      chk("t6_latency", 32'(lat),   32'd2);
      chk("t6_len",     32'(busy),  32'd36);
      chk("t6_pronto",  32'(pr_at), 32'd36);
      chk("t6_bits",    32'(mid),   32'h0182);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
